// File: rtl/traffic_light_ctrl_timed.sv
// Two-approach timed traffic light sequencer with all-red clearance,
// vehicle-actuated main green, latched pedestrian walk and flash mode.
module traffic_light_ctrl_timed #(
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 20,
  parameter int SIDE_GREEN = 10,
  parameter int YELLOW     = 4,
  parameter int ALLRED     = 2,
  parameter int WALK       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       side_car,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ALL_RED_A   = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    ALL_RED_B   = 3'd3,
    SIDE_GRN    = 3'd4,
    SIDE_YELLOW = 3'd5,
    PED_WALK    = 3'd6,
    FLASH       = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_q, ped_d;
  logic             blink_q, blink_d;
  logic             expired;

  assign expired = tick && (cnt_q == '0);

  // Load value (duration-1) for the state being entered.
  function automatic logic [CNT_W-1:0] dur_m1(input state_e s);
    logic [CNT_W-1:0] v;
    v = '0;
    unique case (s)
      ALL_RED_A:   v = CNT_W'(ALLRED - 1);
      MAIN_GREEN:  v = CNT_W'(GREEN_MIN - 1);
      MAIN_YELLOW: v = CNT_W'(YELLOW - 1);
      ALL_RED_B:   v = CNT_W'(ALLRED - 1);
      SIDE_GRN:    v = CNT_W'(SIDE_GREEN - 1);
      SIDE_YELLOW: v = CNT_W'(YELLOW - 1);
      PED_WALK:    v = CNT_W'(WALK - 1);
      FLASH:       v = '0;
    endcase
    return v;
  endfunction

  // Next-state, phase counter, blink and pedestrian latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (tick && cnt_q != '0) cnt_d = cnt_q - 1'b1;
    unique case (state_q)
      ALL_RED_A:
        if (expired) state_d = flash_mode ? FLASH : MAIN_GREEN;
      MAIN_GREEN:
        if (flash_mode) state_d = MAIN_YELLOW;
        else if (expired && (side_car || ped_q))
          state_d = MAIN_YELLOW;
      MAIN_YELLOW:
        if (expired) state_d = ALL_RED_B;
      ALL_RED_B:
        if (expired) begin
          if (flash_mode) state_d = FLASH;
          else if (ped_q) state_d = PED_WALK;
          else            state_d = SIDE_GRN;
        end
      SIDE_GRN:
        if (flash_mode || expired) state_d = SIDE_YELLOW;
      SIDE_YELLOW:
        if (expired) state_d = ALL_RED_A;
      PED_WALK:
        if (expired) state_d = flash_mode ? FLASH : SIDE_GRN;
      FLASH: begin
        if (tick) blink_d = ~blink_q;
        if (!flash_mode) state_d = ALL_RED_A;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = dur_m1(state_d);
      if (state_d == FLASH) blink_d = 1'b1;
    end
    ped_d = ped_q | ped_req;
    if (state_d == PED_WALK && state_q != PED_WALK) ped_d = 1'b0;
  end

  // State register with asynchronous return to the all-red start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ALL_RED_A;
      cnt_q   <= CNT_W'(ALLRED - 1);
      ped_q   <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
      blink_q <= blink_d;
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    main_red    = 1'b0;
    main_yellow = 1'b0;
    main_green  = 1'b0;
    side_red    = 1'b0;
    side_yellow = 1'b0;
    side_green  = 1'b0;
    walk        = 1'b0;
    unique case (state_q)
      ALL_RED_A, ALL_RED_B: begin
        main_red = 1'b1;
        side_red = 1'b1;
      end
      MAIN_GREEN: begin
        main_green = 1'b1;
        side_red   = 1'b1;
      end
      MAIN_YELLOW: begin
        main_yellow = 1'b1;
        side_red    = 1'b1;
      end
      SIDE_GRN: begin
        main_red   = 1'b1;
        side_green = 1'b1;
      end
      SIDE_YELLOW: begin
        main_red    = 1'b1;
        side_yellow = 1'b1;
      end
      PED_WALK: begin
        main_red = 1'b1;
        side_red = 1'b1;
        walk     = 1'b1;
      end
      FLASH: begin
        main_yellow = blink_q;
        side_red    = blink_q;
      end
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl_timed.sv
// Directed scoreboard bench for traffic_light_ctrl_timed.
// Expected phase/lamps are queued before each edge and popped after it.
module tb_traffic_light_ctrl_timed;

  logic       clk = 1'b0;
  logic       reset, tick, side_car, ped_req, flash_mode;
  logic       main_red, main_yellow, main_green;
  logic       side_red, side_yellow, side_green;
  logic       walk;
  logic [2:0] phase;

  traffic_light_ctrl_timed #(
    .CNT_W(8), .GREEN_MIN(4), .SIDE_GREEN(3),
    .YELLOW(2), .ALLRED(1), .WALK(3)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .side_car(side_car), .ped_req(ped_req),
    .flash_mode(flash_mode),
    .main_red(main_red), .main_yellow(main_yellow),
    .main_green(main_green), .side_red(side_red),
    .side_yellow(side_yellow), .side_green(side_green),
    .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [6:0] lm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // {mr,my,mg,sr,sy,sg,walk}
  function automatic logic [6:0] lamps(input logic [2:0] ph,
                                       input logic bl);
    logic [6:0] v;
    case (ph)
      3'd1:    v = 7'b001_100_0;
      3'd2:    v = 7'b010_100_0;
      3'd4:    v = 7'b100_001_0;
      3'd5:    v = 7'b100_010_0;
      3'd6:    v = 7'b100_100_1;
      3'd7:    v = {1'b0, bl, 1'b0, bl, 3'b000};
      default: v = 7'b100_100_0;
    endcase
    return v;
  endfunction

  task automatic push(input logic [2:0] ph, input logic bl = 1'b0);
    exp_t e;
    e.ph = ph;
    e.lm = lamps(ph, bl);
    sb.push_back(e);
  endtask

  task automatic cmp_now(input string tag);
    exp_t e;
    logic [6:0] obs;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: scoreboard empty got phase %0d want entry", tag, phase);
    end else begin
      e = sb.pop_front();
      obs = {main_red, main_yellow, main_green,
             side_red, side_yellow, side_green, walk};
      n_cmp++;
      assert (phase === e.ph) else begin
        n_bad++;
        $error("FAIL %s phase: got %0d want %0d", tag, phase, e.ph);
      end
      n_cmp++;
      assert (obs === e.lm) else begin
        n_bad++;
        $error("FAIL %s lamps: got %b want %b", tag, obs, e.lm);
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    cmp_now(tag);
  endtask

  task automatic run_seq(input string tag, input int q[$]);
    foreach (q[i]) begin
      push(3'(q[i]));
      step(tag);
    end
  endtask

  initial begin
    int prev;
    int tk[$];
    reset = 1'b1;
    tick = 1'b1;
    side_car = 1'b1;
    ped_req = 1'b0;
    flash_mode = 1'b0;
    #12;
    push(3'd0);
    cmp_now("reset");
    reset = 1'b0;

    run_seq("cycle", '{1,1,1,1,2,2,3,4,4,4,5,5,0,1});

    side_car = 1'b0;
    run_seq("hold", '{1,1,1,1,1,1,1,1,1});
    side_car = 1'b1;
    push(3'd2);
    step("car_arrive");
    side_car = 1'b0;
    run_seq("after_car", '{2,3,4,4,4,5,5,0,1});

    ped_req = 1'b1;
    push(3'd1);
    step("ped_pulse");
    ped_req = 1'b0;
    run_seq("ped", '{1,1,2,2,3,6,6,6,4,4,4,5,5,0});
    run_seq("no_rewalk", '{1,1,1,1,1,1});

    side_car = 1'b1;
    push(3'd2);
    step("to_flash");
    side_car = 1'b0;
    run_seq("to_flash", '{2,3,4,4,4,5,5,0,1,1});
    flash_mode = 1'b1;
    run_seq("flash_abort", '{2,2,3});
    push(3'd7, 1'b1); step("blink1");
    push(3'd7, 1'b0); step("blink0");
    push(3'd7, 1'b1); step("blink1");
    push(3'd7, 1'b0); step("blink0");
    flash_mode = 1'b0;
    run_seq("flash_exit", '{0,1});

    side_car = 1'b1;
    tk = '{1,1,1,2,2,3,4,4,4,5,5,0,1};
    prev = 1;
    foreach (tk[i]) begin
      tick = 1'b0;
      push(3'(prev)); step("tick3_idle");
      push(3'(prev)); step("tick3_idle");
      tick = 1'b1;
      push(3'(tk[i])); step("tick3");
      prev = tk[i];
    end

    tick = 1'b0;
    run_seq("frozen", '{1,1,1,1,1});
    flash_mode = 1'b1;
    run_seq("frozen_abort", '{2,2,2});
    tick = 1'b1;
    run_seq("abort_run", '{2,3});
    push(3'd7, 1'b1);
    step("flash_entry");
    flash_mode = 1'b0;
    run_seq("to_side", '{0,1,1,1,1,2,2,3,4});
    ped_req = 1'b1;
    push(3'd4);
    step("ped_in_side");
    ped_req = 1'b0;

    #2;
    reset = 1'b1;
    #1;
    push(3'd0);
    cmp_now("async_reset");
    push(3'd0);
    step("reset_held");
    side_car = 1'b0;
    reset = 1'b0;
    run_seq("post_reset", '{1,1,1,1,1,1,1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
